piece_state_gen: RTL and testbench

Sequential successor to the combinational shape lookup. Holds the active falling piece (shape id, rotation, registered N×N occupancy matrix) and a one-deep "next piece" preview. Draws new pieces from a free-running LFSR. Runs a rotate-request / collision-check handshake with the board logic, so a rotation commits only when the board accepts the candidate matrix. Sits between the game controller (spawn/rotate commands) and the board/collision unit.

---
 rtl/piece_pkg.sv | 62 ++++++
 rtl/piece_rom.sv | 12 +
 rtl/piece_state_gen.sv | 167 ++++++++++++++++
 tb/tb_piece_state_gen.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piece_pkg.sv
// Shared types, shape ROM and LFSR helpers for the falling-piece state generator.
// Matrices are row-major with bit MAT_W-1 at row0/col0.
package piece_pkg;

   localparam int N          = 4;
   localparam int MAT_W      = N * N;
   localparam int NUM_SHAPES = 7;
   localparam int SHAPE_W    = 3;
   localparam int LFSR_W     = 16;

   typedef logic [MAT_W-1:0]   mat_t;
   typedef logic [SHAPE_W-1:0] shape_t;
   typedef logic [1:0]         rot_t;
   typedef logic [LFSR_W-1:0]  lfsr_t;

   localparam lfsr_t LFSR_SEED = 16'hACE1;
   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
   localparam lfsr_t LFSR_TAPS = 16'hB400;

   localparam shape_t SHAPE_I = 3'd0;
   localparam shape_t SHAPE_O = 3'd1;
   localparam shape_t SHAPE_S = 3'd2;
   localparam shape_t SHAPE_Z = 3'd3;
   localparam shape_t SHAPE_T = 3'd4;
   localparam shape_t SHAPE_L = 3'd5;
   localparam shape_t SHAPE_J = 3'd6;

   typedef enum logic {
      IDLE,
      CHECK
   } state_e;

   localparam mat_t SHAPE_ROM [NUM_SHAPES][4] = '{
      '{16'h4444, 16'h0F00, 16'h2222, 16'h00F0},  // I
      '{16'h0660, 16'h0660, 16'h0660, 16'h0660},  // O
      '{16'h6C00, 16'h4620, 16'h06C0, 16'h8C40},  // S
      '{16'hC600, 16'h2640, 16'h0C60, 16'h4C80},  // Z
      '{16'h4E00, 16'h4640, 16'h0E40, 16'h4C40},  // T
      '{16'h2E00, 16'h4460, 16'h0E80, 16'hC440},  // L
      '{16'h8E00, 16'h6440, 16'h0E20, 16'h44C0}   // J
   };

   function automatic mat_t rom_lookup(input shape_t shape, input rot_t rot);
      mat_t m;
      m = '0;
      if (int'(shape) < NUM_SHAPES) m = SHAPE_ROM[shape][rot];
      return m;
   endfunction

   // Single conditional subtract folds the unused code back into range.
   function automatic shape_t draw_shape(input lfsr_t l);
      shape_t d;
      d = l[SHAPE_W-1:0];
      if (d >= shape_t'(NUM_SHAPES)) d = d - shape_t'(NUM_SHAPES);
      return d;
   endfunction

   function automatic lfsr_t lfsr_step(input lfsr_t l);
      return (l >> 1) ^ (l[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/piece_rom.sv
// Combinational (shape, rotation) -> occupancy matrix lookup.
module piece_rom
   import piece_pkg::*;
(
   input  logic [SHAPE_W-1:0] shape,
   input  logic [1:0]         rot,
   output logic [MAT_W-1:0]   matrix
);

   assign matrix = rom_lookup(shape, rot);

endmodule

// File: rtl/piece_state_gen.sv
// Active piece, next-piece preview and rotate/collision-check handshake.
// Matrices are looked up from next-state id/rotation so they never lag their ids.
module piece_state_gen
   import piece_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED        = LFSR_SEED,
   parameter int                CHK_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               seed_load,
   input  logic [LFSR_W-1:0]  seed_val,
   input  logic               spawn_req,
   input  logic               rot_cw,
   input  logic               rot_ccw,
   input  logic               chk_ack,
   input  logic               chk_ok,
   output logic [SHAPE_W-1:0] cur_shape,
   output logic [1:0]         cur_rot,
   output logic [MAT_W-1:0]   cur_matrix,
   output logic [MAT_W-1:0]   cand_matrix,
   output logic               cand_valid,
   output logic [SHAPE_W-1:0] next_shape,
   output logic [MAT_W-1:0]   next_matrix,
   output logic               busy,
   output logic               rot_done,
   output logic               rot_timeout
);

   localparam int          TMR_W    = $clog2(CHK_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CHK_TIMEOUT - 1);
   localparam shape_t      NEXT_RST = draw_shape(SEED);

   state_e             state_q,       state_d;
   lfsr_t              lfsr_q,        lfsr_d;
   shape_t             cur_shape_q,   cur_shape_d;
   rot_t               cur_rot_q,     cur_rot_d;
   mat_t               cur_matrix_q,  cur_matrix_d;
   rot_t               cand_rot_q,    cand_rot_d;
   mat_t               cand_matrix_q, cand_matrix_d;
   logic               cand_valid_q,  cand_valid_d;
   shape_t             next_shape_q,  next_shape_d;
   mat_t               next_matrix_q, next_matrix_d;
   logic [TMR_W-1:0]   timer_q,       timer_d;
   logic               rot_done_q,    rot_done_d;
   logic               rot_timeout_q, rot_timeout_d;

   rot_t               cand_rot_w;
   mat_t               cand_rom_mat;

   assign cand_rot_w = rot_cw ? cur_rot_q + 2'd1 : cur_rot_q - 2'd1;

   piece_rom u_cur_rom (
      .shape  (cur_shape_d),
      .rot    (cur_rot_d),
      .matrix (cur_matrix_d)
   );

   piece_rom u_cand_rom (
      .shape  (cur_shape_q),
      .rot    (cand_rot_w),
      .matrix (cand_rom_mat)
   );

   piece_rom u_next_rom (
      .shape  (next_shape_d),
      .rot    (2'd0),
      .matrix (next_matrix_d)
   );

   always_comb begin
      // NOTE: every _d takes its _q value first so no path can leave it unassigned (no latches).
      state_d       = state_q;
      cur_shape_d   = cur_shape_q;
      cur_rot_d     = cur_rot_q;
      cand_rot_d    = cand_rot_q;
      cand_matrix_d = cand_matrix_q;
      cand_valid_d  = cand_valid_q;
      next_shape_d  = next_shape_q;
      timer_d       = timer_q;
      rot_done_d    = 1'b0;
      rot_timeout_d = 1'b0;
      lfsr_d        = seed_load ? ((seed_val == '0) ? SEED : seed_val) : lfsr_step(lfsr_q);

      if (spawn_req) begin
         // Spawn wins over rotation requests and aborts any pending check.
         cur_shape_d  = next_shape_q;
         cur_rot_d    = 2'd0;
         next_shape_d = draw_shape(lfsr_q);
         cand_valid_d = 1'b0;
         state_d      = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (rot_cw ^ rot_ccw) begin
                  cand_rot_d    = cand_rot_w;
                  cand_matrix_d = cand_rom_mat;
                  cand_valid_d  = 1'b1;
                  timer_d       = '0;
                  state_d       = CHECK;
               end
            end
            CHECK: begin
               if (chk_ack) begin
                  if (chk_ok) begin
                     cur_rot_d  = cand_rot_q;
                     rot_done_d = 1'b1;
                  end
                  cand_valid_d = 1'b0;
                  state_d      = IDLE;
               end else if (timer_q == TMR_LAST) begin
                  rot_timeout_d = 1'b1;
                  cand_valid_d  = 1'b0;
                  state_d       = IDLE;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         lfsr_q        <= SEED;
         cur_shape_q   <= SHAPE_I;
         cur_rot_q     <= 2'd0;
         cur_matrix_q  <= rom_lookup(SHAPE_I, 2'd0);
         cand_rot_q    <= 2'd0;
         cand_matrix_q <= '0;
         cand_valid_q  <= 1'b0;
         next_shape_q  <= NEXT_RST;
         next_matrix_q <= rom_lookup(NEXT_RST, 2'd0);
         timer_q       <= '0;
         rot_done_q    <= 1'b0;
         rot_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lfsr_q        <= lfsr_d;
         cur_shape_q   <= cur_shape_d;
         cur_rot_q     <= cur_rot_d;
         cur_matrix_q  <= cur_matrix_d;
         cand_rot_q    <= cand_rot_d;
         cand_matrix_q <= cand_matrix_d;
         cand_valid_q  <= cand_valid_d;
         next_shape_q  <= next_shape_d;
         next_matrix_q <= next_matrix_d;
         timer_q       <= timer_d;
         rot_done_q    <= rot_done_d;
         rot_timeout_q <= rot_timeout_d;
      end
   end

   assign cur_shape   = cur_shape_q;
   assign cur_rot     = cur_rot_q;
   assign cur_matrix  = cur_matrix_q;
   assign cand_matrix = cand_matrix_q;
   assign cand_valid  = cand_valid_q;
   assign next_shape  = next_shape_q;
   assign next_matrix = next_matrix_q;
   assign busy        = (state_q == CHECK);
   assign rot_done    = rot_done_q;
   assign rot_timeout = rot_timeout_q;

endmodule

// File: tb/tb_piece_state_gen.sv
// Self-checking bench for piece_state_gen: scoreboard of expected shapes/matrices
// against an independent LFSR and shape-table model.
module tb_piece_state_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        seed_load = 1'b0;
   logic [15:0] seed_val = 16'h0;
   logic        spawn_req = 1'b0;
   logic        rot_cw = 1'b0;
   logic        rot_ccw = 1'b0;
   logic        chk_ack = 1'b0;
   logic        chk_ok = 1'b0;

   logic [2:0]  cur_shape;
   logic [1:0]  cur_rot;
   logic [15:0] cur_matrix;
   logic [15:0] cand_matrix;
   logic        cand_valid;
   logic [2:0]  next_shape;
   logic [15:0] next_matrix;
   logic        busy;
   logic        rot_done;
   logic        rot_timeout;

   always #5 clk = ~clk;

   piece_state_gen dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seed_load   (seed_load),
      .seed_val    (seed_val),
      .spawn_req   (spawn_req),
      .rot_cw      (rot_cw),
      .rot_ccw     (rot_ccw),
      .chk_ack     (chk_ack),
      .chk_ok      (chk_ok),
      .cur_shape   (cur_shape),
      .cur_rot     (cur_rot),
      .cur_matrix  (cur_matrix),
      .cand_matrix (cand_matrix),
      .cand_valid  (cand_valid),
      .next_shape  (next_shape),
      .next_matrix (next_matrix),
      .busy        (busy),
      .rot_done    (rot_done),
      .rot_timeout (rot_timeout)
   );

   int checks = 0;
   int errors = 0;
   int hist [7];

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;
   exp_t sb_q [$];

   logic [15:0] lfsr_m;
   logic [2:0]  cur_m;
   logic [2:0]  next_m;
   logic [1:0]  rot_m;

   // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting Galois form.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_m <= 16'hACE1;
      else if (seed_load) lfsr_m <= (seed_val == 16'h0) ? 16'hACE1 : seed_val;
      else lfsr_m <= {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0);
   end

   function automatic logic [15:0] rom_m(input logic [2:0] s, input logic [1:0] r);
      logic [15:0] row [4];
      case (s)
         3'd0:    row = '{16'h4444, 16'h0F00, 16'h2222, 16'h00F0};
         3'd1:    row = '{16'h0660, 16'h0660, 16'h0660, 16'h0660};
         3'd2:    row = '{16'h6C00, 16'h4620, 16'h06C0, 16'h8C40};
         3'd3:    row = '{16'hC600, 16'h2640, 16'h0C60, 16'h4C80};
         3'd4:    row = '{16'h4E00, 16'h4640, 16'h0E40, 16'h4C40};
         3'd5:    row = '{16'h2E00, 16'h4460, 16'h0E80, 16'hC440};
         3'd6:    row = '{16'h8E00, 16'h6440, 16'h0E20, 16'h44C0};
         default: row = '{16'h0, 16'h0, 16'h0, 16'h0};
      endcase
      return row[r];
   endfunction

   function automatic logic [2:0] draw_m(input logic [15:0] l);
      logic [2:0] d;
      d = l[2:0];
      if (d == 3'd7) d = 3'd0;
      return d;
   endfunction

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic sb_push(input string tag, input logic [15:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (cur_shape !== 3'd0) begin errors++; $display("FAIL reset_cur_shape: got %0d want 0", cur_shape); end
      checks++; if (cur_rot !== 2'd0) begin errors++; $display("FAIL reset_cur_rot: got %0d want 0", cur_rot); end
      checks++; if (cur_matrix !== 16'h4444) begin errors++; $display("FAIL reset_cur_matrix: got %h want 4444", cur_matrix); end
      checks++; if (cand_matrix !== 16'h0) begin errors++; $display("FAIL reset_cand_matrix: got %h want 0000", cand_matrix); end
      checks++; if (cand_valid !== 1'b0) begin errors++; $display("FAIL reset_cand_valid: got %b want 0", cand_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (next_shape !== 3'd1) begin errors++; $display("FAIL reset_next_shape: got %0d want 1", next_shape); end
      checks++; if (next_matrix !== 16'h0660) begin errors++; $display("FAIL reset_next_matrix: got %h want 0660", next_matrix); end
      checks++; if ({rot_done, rot_timeout} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {rot_done, rot_timeout}); end
      rst_n = 1'b1;
      cur_m = 3'd0; rot_m = 2'd0; next_m = 3'd1;
      tick;
   endtask

   task automatic spawn_one;
      exp_t e;
      logic [2:0] en, ec;
      en = draw_m(lfsr_m);
      ec = next_m;
      sb_push("spawn_cur_shape", {13'd0, ec});
      sb_push("spawn_next_shape", {13'd0, en});
      spawn_req = 1'b1;
      tick;
      spawn_req = 1'b0;
      e = sb_q.pop_front();
      checks++; if ({13'd0, cur_shape} !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.tag, cur_shape, e.val); end
      e = sb_q.pop_front();
      checks++; if ({13'd0, next_shape} !== e.val) begin errors++; $display("FAIL %s: got %0d want %0d", e.tag, next_shape, e.val); end
      checks++; if (cur_rot !== 2'd0) begin errors++; $display("FAIL spawn_cur_rot: got %0d want 0", cur_rot); end
      checks++; if (cur_matrix !== rom_m(ec, 2'd0)) begin errors++; $display("FAIL spawn_cur_matrix: got %h want %h", cur_matrix, rom_m(ec, 2'd0)); end
      checks++; if (next_matrix !== rom_m(en, 2'd0)) begin errors++; $display("FAIL spawn_next_matrix: got %h want %h", next_matrix, rom_m(en, 2'd0)); end
      checks++; if (next_shape > 3'd6) begin errors++; $display("FAIL spawn_next_range: got %0d want 0..6", next_shape); end
      else hist[next_shape]++;
      cur_m = ec; next_m = en; rot_m = 2'd0;
   endtask

   task automatic bring_shape(input logic [2:0] target);
      int n;
      n = 0;
      while (next_m != target && n < 300) begin
         spawn_one;
         n++;
      end
      checks++; if (next_m != target) begin errors++; $display("FAIL bring_shape_%0d: got next %0d want %0d within 300 spawns", target, next_m, target); end
      spawn_one;
   endtask

   task automatic do_rotate(input bit cw, input int wait_cycles, input bit ok, input bit noise);
      exp_t e;
      logic [1:0] cr;
      cr = cw ? rot_m + 2'd1 : rot_m - 2'd1;
      sb_push("cand_matrix", rom_m(cur_m, cr));
      rot_cw = cw; rot_ccw = !cw;
      tick;
      rot_cw = 1'b0; rot_ccw = 1'b0;
      e = sb_q.pop_front();
      checks++; if (cand_matrix !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.tag, cand_matrix, e.val); end
      checks++; if (cand_valid !== 1'b1) begin errors++; $display("FAIL cand_valid_set: got %b want 1", cand_valid); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_set: got %b want 1", busy); end
      for (int i = 0; i < wait_cycles; i++) begin
         if (noise && i == 0) begin rot_cw = !cw; rot_ccw = cw; end
         tick;
         rot_cw = 1'b0; rot_ccw = 1'b0;
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_hold: got %b want 1", busy); end
      if (ok) rot_m = cr;
      sb_push("commit_matrix", rom_m(cur_m, rot_m));
      chk_ack = 1'b1; chk_ok = ok;
      tick;
      chk_ack = 1'b0; chk_ok = 1'b0;
      e = sb_q.pop_front();
      checks++; if (cur_matrix !== e.val) begin errors++; $display("FAIL %s: got %h want %h", e.tag, cur_matrix, e.val); end
      checks++; if (cur_rot !== rot_m) begin errors++; $display("FAIL commit_rot: got %0d want %0d", cur_rot, rot_m); end
      checks++; if (rot_done !== ok) begin errors++; $display("FAIL rot_done_pulse: got %b want %b", rot_done, ok); end
      checks++; if ({busy, cand_valid, rot_timeout} !== 3'b000) begin errors++; $display("FAIL ack_exit: busy/cand_valid/timeout got %b want 000", {busy, cand_valid, rot_timeout}); end
      tick;
      checks++; if (rot_done !== 1'b0) begin errors++; $display("FAIL rot_done_width: got %b want 0", rot_done); end
   endtask

   task automatic test_rotate_commit;
      bring_shape(3'd4);
      do_rotate(1'b1, 1, 1'b1, 1'b0);
      checks++; if (cur_matrix !== 16'h4640) begin errors++; $display("FAIL t_cw_matrix: got %h want 4640", cur_matrix); end
   endtask

   task automatic test_rotate_reject;
      bring_shape(3'd0);
      do_rotate(1'b0, 0, 1'b0, 1'b0);
      checks++; if (cur_matrix !== 16'h4444) begin errors++; $display("FAIL i_reject_matrix: got %h want 4444", cur_matrix); end
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 4; i++) do_rotate(1'b1, (i == 1) ? 2 : 0, 1'b1, i == 1);
      do_rotate(1'b0, 0, 1'b1, 1'b0);
      checks++; if (cur_rot !== 2'd3) begin errors++; $display("FAIL ccw_wrap: got %0d want 3", cur_rot); end
      do_rotate(1'b1, 0, 1'b1, 1'b0);
      rot_cw = 1'b1; rot_ccw = 1'b1;
      tick;
      rot_cw = 1'b0; rot_ccw = 1'b0;
      checks++; if ({busy, cand_valid} !== 2'b00) begin errors++; $display("FAIL both_dirs_noop: got %b want 00", {busy, cand_valid}); end
   endtask

   task automatic test_o_shape;
      bring_shape(3'd1);
      do_rotate(1'b1, 0, 1'b1, 1'b0);
   endtask

   task automatic test_timeout;
      int n;
      rot_cw = 1'b1;
      tick;
      rot_cw = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_enter: got %b want 1", busy); end
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         checks++; if (rot_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got pulse at cycle %0d", n); end
         tick;
         n++;
      end
      checks++; if (n != 15) begin errors++; $display("FAIL timeout_cycles: got %0d want 15", n); end
      checks++; if (rot_timeout !== 1'b1) begin errors++; $display("FAIL timeout_pulse: got %b want 1", rot_timeout); end
      checks++; if (cur_rot !== rot_m || cur_matrix !== rom_m(cur_m, rot_m)) begin errors++; $display("FAIL timeout_cur: got %0d/%h want %0d/%h", cur_rot, cur_matrix, rot_m, rom_m(cur_m, rot_m)); end
      checks++; if ({cand_valid, rot_done} !== 2'b00) begin errors++; $display("FAIL timeout_flags: got %b want 00", {cand_valid, rot_done}); end
      tick;
      checks++; if (rot_timeout !== 1'b0) begin errors++; $display("FAIL timeout_width: got %b want 0", rot_timeout); end
   endtask

   task automatic test_spawn_beats_ack;
      logic [2:0] en, ec;
      rot_cw = 1'b1;
      tick;
      rot_cw = 1'b0;
      en = draw_m(lfsr_m);
      ec = next_m;
      spawn_req = 1'b1; chk_ack = 1'b1; chk_ok = 1'b1;
      tick;
      spawn_req = 1'b0; chk_ack = 1'b0; chk_ok = 1'b0;
      checks++; if (cur_shape !== ec) begin errors++; $display("FAIL spawn_ack_cur_shape: got %0d want %0d", cur_shape, ec); end
      checks++; if (next_shape !== en) begin errors++; $display("FAIL spawn_ack_next_shape: got %0d want %0d", next_shape, en); end
      checks++; if (cur_rot !== 2'd0 || cur_matrix !== rom_m(ec, 2'd0)) begin errors++; $display("FAIL spawn_ack_cur: got %0d/%h want 0/%h", cur_rot, cur_matrix, rom_m(ec, 2'd0)); end
      checks++; if ({rot_done, busy, cand_valid} !== 3'b000) begin errors++; $display("FAIL spawn_ack_flags: got %b want 000", {rot_done, busy, cand_valid}); end
      cur_m = ec; next_m = en; rot_m = 2'd0;
      tick;
      checks++; if (rot_done !== 1'b0) begin errors++; $display("FAIL spawn_ack_late_done: got %b want 0", rot_done); end
   endtask

   task automatic test_reset_mid_check;
      spawn_one;
      rot_cw = 1'b1;
      tick;
      rot_cw = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_enter: got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      checks++; if ({busy, cand_valid} !== 2'b00) begin errors++; $display("FAIL midrst_flags: got %b want 00", {busy, cand_valid}); end
      checks++; if (cur_shape !== 3'd0 || cur_rot !== 2'd0 || cur_matrix !== 16'h4444) begin errors++; $display("FAIL midrst_cur: got %0d/%0d/%h want 0/0/4444", cur_shape, cur_rot, cur_matrix); end
      checks++; if (next_shape !== 3'd1 || cand_matrix !== 16'h0) begin errors++; $display("FAIL midrst_next_cand: got %0d/%h want 1/0000", next_shape, cand_matrix); end
      @(negedge clk);
      rst_n = 1'b1;
      cur_m = 3'd0; rot_m = 2'd0; next_m = 3'd1;
      tick;
   endtask

   task automatic test_distribution;
      seed_load = 1'b1; seed_val = 16'h0;
      tick;
      seed_load = 1'b0;
      spawn_one;
      checks++; if (next_shape !== 3'd1) begin errors++; $display("FAIL seed_zero_draw: got %0d want 1", next_shape); end
      for (int s = 0; s < 7; s++) hist[s] = 0;
      repeat (10000) spawn_one;
      for (int s = 0; s < 7; s++) begin
         checks++; if (hist[s] < 1000) begin errors++; $display("FAIL dist_shape_%0d: got %0d want >= 1000", s, hist[s]); end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int s = 0; s < 7; s++) hist[s] = 0;
      test_reset;
      repeat (3) spawn_one;
      test_rotate_commit;
      test_rotate_reject;
      test_wrap;
      test_timeout;
      test_o_shape;
      test_spawn_beats_ack;
      test_reset_mid_check;
      test_distribution;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
